// File: rtl/mips_mem_pkg.sv
// Shared memory-path definitions: access size encodings and the store FIFO entry layout.
package mips_mem_pkg;

    localparam int unsigned DATA_W  = 32;
    localparam int unsigned ADDR_W  = 32;
    localparam int unsigned BE_W    = DATA_W / 8;
    localparam int unsigned WADDR_W = ADDR_W - 2;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10,
        SZ_ILL  = 2'b11
    } size_t;

    typedef struct packed {
        logic [WADDR_W-1:0] addr_w;
        logic [DATA_W-1:0]  wdata;
        logic [BE_W-1:0]    be;
    } store_entry_t;

endpackage

// File: rtl/store_lane_align.sv
// Combinational lane placement, byte enables and alignment check for one store.
module store_lane_align
    import mips_mem_pkg::*;
(
    input  logic [1:0]        addr_lo,
    input  logic [DATA_W-1:0] data,
    input  size_t             size,
    output logic [DATA_W-1:0] wdata_c,
    output logic [BE_W-1:0]   be_c,
    output logic              misalign_c
);

    always_comb begin
        wdata_c    = data;
        be_c       = 4'b1111;
        misalign_c = 1'b0;
        case (size)
            SZ_BYTE: begin
                wdata_c = {4{data[7:0]}};
                be_c    = 4'b0001 << addr_lo;
            end
            SZ_HALF: begin
                wdata_c    = {2{data[15:0]}};
                be_c       = addr_lo[1] ? 4'b1100 : 4'b0011;
                misalign_c = addr_lo[0];
            end
            SZ_WORD: misalign_c = (addr_lo != 2'b00);
            default: misalign_c = 1'b1;
        endcase
    end

endmodule

// File: rtl/store_narrower.sv
// Store path: narrows execute-stage stores into byte-enabled word writes and
// buffers them in a small FIFO that drains to data memory over valid/ready.
module store_narrower
    import mips_mem_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_addr,
    input  logic [31:0] in_data,
    input  logic [1:0]  in_size,
    input  logic        flush,
    output logic        mem_valid,
    input  logic        mem_ready,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_be,
    output logic        misalign,
    output logic [31:0] misalign_addr,
    output logic        empty
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  count;
    store_entry_t      fifo_q [DEPTH];
    store_entry_t      head;

    logic [DATA_W-1:0] lane_wdata;
    logic [BE_W-1:0]   lane_be;
    logic              lane_mis;
    logic              accept;
    logic              push;
    logic              pop;

    store_lane_align u_align (
        .addr_lo    (in_addr[1:0]),
        .data       (in_data),
        .size       (size_t'(in_size)),
        .wdata_c    (lane_wdata),
        .be_c       (lane_be),
        .misalign_c (lane_mis)
    );

    // Head of the FIFO is always presented; a pop frees a slot the same cycle.
    assign head      = fifo_q[rd_ptr];
    assign mem_valid = (count != '0);
    assign empty     = (count == '0);
    assign mem_addr  = {head.addr_w, 2'b00};
    assign mem_wdata = head.wdata;
    assign mem_be    = head.be;

    assign pop      = mem_valid && mem_ready && !flush;
    assign in_ready = !flush && ((count < CNT_W'(DEPTH)) || (mem_valid && mem_ready));
    assign accept   = in_valid && in_ready;
    assign push     = accept && !lane_mis;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) fifo_q[i] <= '0;
        end else if (push) begin
            fifo_q[wr_ptr] <= '{addr_w: in_addr[31:2], wdata: lane_wdata, be: lane_be};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Rejected requests are consumed; report them for one cycle and keep the address.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            misalign      <= 1'b0;
            misalign_addr <= '0;
        end else begin
            misalign <= accept && lane_mis;
            if (accept && lane_mis) misalign_addr <= in_addr;
        end
    end

endmodule

// File: tb/tb_store_narrower.sv
// Self-checking bench for store_narrower: directed scenarios plus randomized
// traffic against a queue-based reference model.
module tb_store_narrower;

    localparam int DEPTH = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_addr;
    logic [31:0] in_data;
    logic [1:0]  in_size;
    logic        flush;
    logic        mem_valid;
    logic        mem_ready;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_be;
    logic        misalign;
    logic [31:0] misalign_addr;
    logic        empty;

    store_narrower #(.DEPTH(DEPTH)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_addr       (in_addr),
        .in_data       (in_data),
        .in_size       (in_size),
        .flush         (flush),
        .mem_valid     (mem_valid),
        .mem_ready     (mem_ready),
        .mem_addr      (mem_addr),
        .mem_wdata     (mem_wdata),
        .mem_be        (mem_be),
        .misalign      (misalign),
        .misalign_addr (misalign_addr),
        .empty         (empty)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
    } ref_t;

    ref_t        q[$];
    logic        exp_mis;
    logic [31:0] exp_mis_addr;
    int          n_checks;
    int          n_err;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Drive one cycle of inputs, compare every output with the model, then advance the model.
    task automatic cycle(input logic v, input logic [31:0] a, input logic [31:0] d,
                         input logic [1:0] s, input logic mr, input logic fl);
        ref_t e;
        logic exp_rdy;
        logic acc;
        logic bad;
        in_valid = v; in_addr = a; in_data = d; in_size = s; mem_ready = mr; flush = fl;
        #1;
        exp_rdy = !fl && (q.size() < DEPTH || (q.size() > 0 && mr));
        check("in_ready", 32'(in_ready), 32'(exp_rdy));
        check("mem_valid", 32'(mem_valid), 32'(q.size() > 0));
        check("empty", 32'(empty), 32'(q.size() == 0));
        check("misalign", 32'(misalign), 32'(exp_mis));
        check("misalign_addr", misalign_addr, exp_mis_addr);
        if (q.size() > 0) begin
            check("mem_addr", mem_addr, q[0].addr);
            check("mem_wdata", mem_wdata, q[0].wdata);
            check("mem_be", 32'(mem_be), 32'(q[0].be));
        end
        bad = (s == 2'd3) || (s == 2'd1 && a[0]) || (s == 2'd2 && a[1:0] != 2'd0);
        e.addr = {a[31:2], 2'b00};
        case (s)
            2'd0: begin e.wdata = 32'(d[7:0]) * 32'h0101_0101;  e.be = 4'(1 << a[1:0]); end
            2'd1: begin e.wdata = 32'(d[15:0]) * 32'h0001_0001; e.be = a[1] ? 4'hC : 4'h3; end
            default: begin e.wdata = d; e.be = 4'hF; end
        endcase
        acc = v && exp_rdy;
        @(posedge clk);
        if (fl) q.delete();
        else begin
            if (q.size() > 0 && mr) void'(q.pop_front());
            if (acc && !bad) q.push_back(e);
        end
        exp_mis = acc && bad;
        if (acc && bad) exp_mis_addr = a;
        @(negedge clk);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
        check({tag, "_mem_valid"}, 32'(mem_valid), 32'd0);
        check({tag, "_mem_addr"}, mem_addr, 32'd0);
        check({tag, "_mem_wdata"}, mem_wdata, 32'd0);
        check({tag, "_mem_be"}, 32'(mem_be), 32'd0);
        check({tag, "_misalign"}, 32'(misalign), 32'd0);
        check({tag, "_misalign_addr"}, misalign_addr, 32'd0);
        check({tag, "_empty"}, 32'(empty), 32'd1);
    endtask

    // Assert reset between clock edges and expect every output cleared before the next edge.
    task automatic async_reset();
        in_valid = 1'b1; in_addr = 32'h0000_5000; in_size = 2'd2; mem_ready = 1'b0; flush = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("async_rst");
        q.delete();
        exp_mis = 1'b0;
        exp_mis_addr = '0;
        @(negedge clk);
        in_valid = 1'b0;
        rst_n = 1'b1;
    endtask

    initial begin
        n_checks = 0; n_err = 0;
        exp_mis = 1'b0; exp_mis_addr = '0;
        rst_n = 1'b0; in_valid = 1'b0; in_addr = '0; in_data = '0; in_size = '0;
        flush = 1'b0; mem_ready = 1'b0;
        repeat (2) @(negedge clk);
        check_reset_outputs("reset");
        rst_n = 1'b1;

        // sb at byte 3, then drained immediately
        cycle(1'b1, 32'h0000_1003, 32'hAABB_CCDD, 2'd0, 1'b1, 1'b0);
        #1;
        check("tp_sb_addr", mem_addr, 32'h0000_1000);
        check("tp_sb_wdata", mem_wdata, 32'hDDDD_DDDD);
        check("tp_sb_be", 32'(mem_be), 32'h8);
        cycle(1'b0, 32'h0, 32'h0, 2'd0, 1'b1, 1'b0);
        cycle(1'b0, 32'h0, 32'h0, 2'd0, 1'b1, 1'b0);

        // sh upper half, sw
        cycle(1'b1, 32'h0000_2002, 32'h1234_5678, 2'd1, 1'b1, 1'b0);
        #1;
        check("tp_sh_wdata", mem_wdata, 32'h5678_5678);
        check("tp_sh_be", 32'(mem_be), 32'hC);
        cycle(1'b1, 32'h0000_2004, 32'hCAFE_F00D, 2'd2, 1'b1, 1'b0);
        #1;
        check("tp_sw_addr", mem_addr, 32'h0000_2004);
        check("tp_sw_be", 32'(mem_be), 32'hF);
        cycle(1'b0, 32'h0, 32'h0, 2'd0, 1'b1, 1'b0);

        // two back-to-back misaligned requests
        cycle(1'b1, 32'h0000_3001, 32'h1111_1111, 2'd1, 1'b1, 1'b0);
        cycle(1'b1, 32'h0000_3006, 32'h2222_2222, 2'd2, 1'b1, 1'b0);
        cycle(1'b0, 32'h0, 32'h0, 2'd0, 1'b1, 1'b0);
        cycle(1'b0, 32'h0, 32'h0, 2'd0, 1'b1, 1'b0);
        cycle(1'b1, 32'h0000_3008, 32'h3333_3333, 2'd3, 1'b1, 1'b0);

        // fill with mem_ready low, third waits, then drain with push/pop on full
        cycle(1'b1, 32'h0000_4000, 32'hA0A0_A0A0, 2'd2, 1'b0, 1'b0);
        cycle(1'b1, 32'h0000_4005, 32'h0000_00B1, 2'd0, 1'b0, 1'b0);
        cycle(1'b1, 32'h0000_4008, 32'hC2C2_C2C2, 2'd2, 1'b0, 1'b0);
        cycle(1'b1, 32'h0000_4008, 32'hC2C2_C2C2, 2'd2, 1'b0, 1'b0);
        cycle(1'b1, 32'h0000_4008, 32'hC2C2_C2C2, 2'd2, 1'b1, 1'b0);
        cycle(1'b0, 32'h0, 32'h0, 2'd0, 1'b1, 1'b0);
        cycle(1'b0, 32'h0, 32'h0, 2'd0, 1'b1, 1'b0);
        cycle(1'b0, 32'h0, 32'h0, 2'd0, 1'b1, 1'b0);

        // flush while full and stalled, alongside a new request
        cycle(1'b1, 32'h0000_5000, 32'h5555_5555, 2'd2, 1'b0, 1'b0);
        cycle(1'b1, 32'h0000_5004, 32'h6666_6666, 2'd2, 1'b0, 1'b0);
        cycle(1'b1, 32'h0000_5008, 32'h7777_7777, 2'd2, 1'b1, 1'b1);
        #1;
        check("tp_flush_empty", 32'(empty), 32'd1);
        check("tp_flush_mem_valid", 32'(mem_valid), 32'd0);
        cycle(1'b0, 32'h0, 32'h0, 2'd0, 1'b1, 1'b0);

        // async reset mid-burst
        cycle(1'b1, 32'h0000_6001, 32'h0000_0042, 2'd1, 1'b0, 1'b0);
        cycle(1'b1, 32'h0000_6002, 32'h0000_ABCD, 2'd1, 1'b0, 1'b0);
        cycle(1'b1, 32'h0000_6003, 32'h0000_00EF, 2'd0, 1'b0, 1'b0);
        async_reset();

        // randomized traffic with varying memory backpressure
        for (int blk = 0; blk < 20; blk++) begin
            int unsigned rdy_pct;
            rdy_pct = $urandom_range(10, 100);
            for (int i = 0; i < 80; i++) begin
                logic [31:0] a;
                logic [1:0]  s;
                a = 32'h0000_8000 + 32'($urandom_range(0, 63));
                s = 2'($urandom_range(0, 9) < 8 ? $urandom_range(0, 2) : 3);
                cycle(1'($urandom_range(0, 3) != 0), a, $urandom, s,
                      1'($urandom_range(1, 100) <= rdy_pct),
                      1'($urandom_range(0, 29) == 0));
            end
            if (blk == 10) async_reset();
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
